// File: rtl/pinwheel_lsu_pkg.sv
// pinwheel_lsu_pkg: shared types for the pinwheel load/store unit.
// Size and state enums, byte-mask constants and the byte-mask helper.
package pinwheel_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_RSV = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD    = 3'd1,
    LD_LO = 3'd2,
    LD_HI = 3'd3,
    ST_HI = 3'd4
  } state_e;

  localparam logic [7:0] BM_B = 8'h01;
  localparam logic [7:0] BM_H = 8'h03;
  localparam logic [7:0] BM_W = 8'h0F;

  // Lane mask across two adjacent words; bits 7:4 are the next word.
  function automatic logic [7:0] byte_mask(
    input size_e      s,
    input logic [1:0] off
  );
    logic [7:0] m;
    case (s)
      SIZE_B:  m = BM_B;
      SIZE_H:  m = BM_H;
      SIZE_W:  m = BM_W;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts a 64-bit load window by the byte offset and
// truncates/extends to the access size. Ports: i_win, i_off, i_size,
// i_signed in; o_data out. Purely combinational.
module lsu_load_align
  import pinwheel_lsu_pkg::*;
(
  input  logic [63:0] i_win,
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;

  assign w_sh = 32'(i_win >> {i_off, 3'b000});

  always_comb begin
    o_data = '0;
    unique case (i_size)
      SIZE_B:   o_data = {{24{i_signed & w_sh[7]}}, w_sh[7:0]};
      SIZE_H:   o_data = {{16{i_signed & w_sh[15]}}, w_sh[15:0]};
      SIZE_W:   o_data = w_sh;
      SIZE_RSV: o_data = '0;
    endcase
  end

endmodule

// File: rtl/pinwheel_lsu.sv
// pinwheel_lsu: CPU request -> word RAM load/store unit with byte masks.
// Ports: req_* handshake in, rsp_* pulse out, mem_* RAM side.
// LSU_MISALIGNED_EN: split word-crossing accesses; otherwise they fault.
module pinwheel_lsu
  import pinwheel_lsu_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic                 req_wr,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_fault,
  output logic [ADDR_BITS-3:0] mem_raddr,
  input  logic [31:0]          mem_rdata,
  output logic [ADDR_BITS-3:0] mem_waddr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wmask,
  output logic                 mem_wren
);

  localparam int AW = ADDR_BITS - 2;

  state_e               r_state;
  logic [ADDR_BITS-1:0] r_addr;
  size_e                r_size;
  logic                 r_signed;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_data;
  logic                 r_rsp_fault;

  size_e       w_size;
  logic [1:0]  w_off;
  logic [AW-1:0] w_w;
  logic [AW-1:0] w_rw;
  logic [7:0]  w_bm;
  logic        w_mis;
  logic        w_fault;
  logic [31:0] w_wlo;
  logic [63:0] w_win;
  logic [31:0] w_ldata;

`ifdef LSU_MISALIGNED_EN
  logic [31:0] r_whi;
  logic [3:0]  r_mhi;
  logic [31:0] r_lo;
  logic [63:0] w_wide;
`endif

  assign w_size = size_e'(req_size);
  assign w_off  = req_addr[1:0];
  assign w_w    = req_addr[ADDR_BITS-1:2];
  assign w_rw   = r_addr[ADDR_BITS-1:2];
  assign w_bm   = byte_mask(w_size, w_off);
  assign w_mis  = |w_bm[7:4];

`ifdef LSU_MISALIGNED_EN
  assign w_fault = (w_size == SIZE_RSV);
  // Upper half of the shifted store data is the second-word payload.
  assign w_wide  = {32'b0, req_wdata} << {w_off, 3'b000};
  assign w_wlo   = w_wide[31:0];
  assign w_win   = (r_state == LD_HI) ? {mem_rdata, r_lo}
                                      : {32'b0, mem_rdata};
`else
  assign w_fault = (w_size == SIZE_RSV) | w_mis;
  assign w_wlo   = req_wdata << {w_off, 3'b000};
  assign w_win   = {32'b0, mem_rdata};
`endif

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;

  lsu_load_align u_align (
    .i_win    (w_win),
    .i_off    (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ldata)
  );

  always_comb begin
    mem_raddr = w_w;
    mem_waddr = w_w;
    mem_wdata = w_wlo;
    mem_wmask = w_bm[3:0];
    mem_wren  = 1'b0;
    case (r_state)
      IDLE: mem_wren = req_valid & req_wr & ~w_fault;
`ifdef LSU_MISALIGNED_EN
      LD_LO: mem_raddr = w_rw + AW'(1);
      ST_HI: begin
        mem_waddr = w_rw + AW'(1);
        mem_wdata = r_whi;
        mem_wmask = r_mhi;
        mem_wren  = 1'b1;
      end
`endif
      default: begin
        mem_raddr = w_rw;
        mem_waddr = w_rw;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= SIZE_B;
      r_signed    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      r_whi       <= '0;
      r_mhi       <= '0;
      r_lo        <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_size   <= w_size;
            r_signed <= req_signed;
`ifdef LSU_MISALIGNED_EN
            r_whi    <= w_wide[63:32];
            r_mhi    <= w_bm[7:4];
`endif
            if (w_fault) begin
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= 1'b1;
            end else if (req_wr) begin
`ifdef LSU_MISALIGNED_EN
              if (w_mis) r_state <= ST_HI;
              else r_rsp_valid <= 1'b1;
`else
              r_rsp_valid <= 1'b1;
`endif
            end else begin
`ifdef LSU_MISALIGNED_EN
              if (w_mis) r_state <= LD_LO;
              else r_state <= LD;
`else
              r_state <= LD;
`endif
            end
          end
        end
        LD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_ldata;
          r_state     <= IDLE;
        end
`ifdef LSU_MISALIGNED_EN
        LD_LO: begin
          r_lo    <= mem_rdata;
          r_state <= LD_HI;
        end
        LD_HI: begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_ldata;
          r_state     <= IDLE;
        end
        ST_HI: begin
          r_rsp_valid <= 1'b1;
          r_state     <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pinwheel_lsu.md
# pinwheel_lsu

Load/store unit that sits directly upstream of the 256-word, byte-masked data RAM. It accepts byte-addressed CPU requests for bytes, halfwords and words, and turns them into word-aligned RAM reads and masked writes. Load data comes back shifted into place and zero- or sign-extended. Word-crossing (misaligned) accesses are split into two RAM accesses by a small state machine; this behaviour is optional.

## Interface
Parameters:
- ADDR_BITS, 10, byte-address width; RAM word address is ADDR_BITS-2 bits (8 by default).

Ports:
- One clock; reset is asynchronous and active-low.
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; request accepted when valid && ready.
- req_addr  in  ADDR_BITS  byte address.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  sign-extend load result.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  load result (0 for stores/faults).
- rsp_fault  out  1  access rejected, qualified by rsp_valid.
- mem_raddr  out  ADDR_BITS-2  RAM read word address.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_raddr.
- mem_waddr  out  ADDR_BITS-2  RAM write word address.
- mem_wdata  out  32  RAM write data, lane-aligned.
- mem_wmask  out  4  byte write enables.
- mem_wren  out  1  RAM write strobe.

## Operation
- Terms: off = req_addr[1:0]; w = req_addr >> 2.
- Byte mask: bm = {1, 3, 15}[size] << off. This is an 8-bit value.
- An access is misaligned when bm[7:4] != 0.
- States and transitions:
  - IDLE: req_ready = 1. Outputs are combinational from the request on the accept cycle.
  - Aligned store: mem_wren = 1, mem_waddr = w, mem_wmask = bm[3:0], mem_wdata = req_wdata << 8*off. Next state IDLE; rsp_valid next cycle.
  - Aligned load: mem_raddr = w. Next state LD.
  - Misaligned store: first write as above, using bm[3:0]. Latch the request, then go to ST_HI.
  - Misaligned load: mem_raddr = w. Latch the request, then go to LD_LO.
  - ST_HI: write word w+1 with mask bm[7:4] and data req_wdata >> 8*(4-off). Next state IDLE; rsp_valid next cycle.
  - LD_LO: hold mem_rdata into lo; mem_raddr = w+1. Next state LD_HI.
  - LD: rsp_data is computed from {0, mem_rdata}. Next state IDLE; rsp_valid registered.
  - LD_HI: rsp_data is computed from {mem_rdata, lo}. Next state IDLE; rsp_valid registered.
- Load extract: shift the 64-bit value right by 8*off, then truncate to size. Sign-extend from bit 7 or 15 if req_signed; otherwise zero-extend.
- Word-address arithmetic: w+1 wraps modulo 2^(ADDR_BITS-2), so 0xFF+1 = 0x00.
- size = 3: no RAM access; rsp_valid next cycle with rsp_fault = 1 and rsp_data = 0.
- mem_wren = 0 in every state except the store-issue cycles.
- Reset values:
  - state = IDLE; rsp_valid = 0, rsp_data = 0, rsp_fault = 0; latched request cleared.
  - Reset during ST_HI leaves only the low half written.

## Timing
- Latency from accept cycle N to rsp_valid:
  - Aligned store: N+1.
  - Aligned load: N+2.
  - Split store: N+2.
  - Split load: N+3.
  - Fault: N+1.
- Only one request is outstanding at a time. req_ready = 1 only in IDLE.
- Back-to-back aligned stores can be accepted every cycle.
- There is no response backpressure; rsp_valid is exactly one cycle wide.
- Store-to-load ordering: a load accepted after a store reads the written data. This follows from the RAM's write-through bypass combined with in-order issue.

## Configuration
- LSU_MISALIGNED_EN defined: misaligned accesses are split as described above.
- LSU_MISALIGNED_EN undefined:
  - Any misaligned access performs no RAM access.
  - rsp_valid at N+1 with rsp_fault = 1 and rsp_data = 0.
  - States ST_HI, LD_LO and LD_HI and the lo register are not built.

## Structure
- pinwheel_lsu_pkg holds:
  - the size enum (SIZE_B, SIZE_H, SIZE_W, SIZE_RSV);
  - the state enum (IDLE, LD, LD_LO, LD_HI, ST_HI);
  - the byte-mask constants.
- Sub-module lsu_load_align is combinational, and is shared by the LD and LD_HI paths.
  - Inputs: 64-bit window, off, size, signed.
  - Output: 32-bit result.

## Test plan
- Store word 0xDEADBEEF to 0x010, then load word from 0x010: rsp_data = 0xDEADBEEF at accept+2, rsp_fault = 0.
- Byte store 0x80 to 0x013, then signed byte load from 0x013: mem_wmask = 4'b1000, rsp_data = 0xFFFFFF80. The unsigned load returns 0x00000080.
- Split access (macro on):
  - Store half 0xA1B2 to 0x007: writes word 1 with mask 1000 and word 2 with mask 0001.
  - Signed half load from 0x007 returns 0xFFFFA1B2 at accept+3.
- Wrap (macro on): store word 0x11223344 to 0x3FE. Writes word 0xFF with mask 1100 (lanes 2–3 = 0x3344) and word 0x00 with mask 0011 (lanes 0–1 = 0x1122).
- Macro off: load word from 0x001 gives rsp_fault = 1 at accept+1 with no mem_wren. req_size = 3 faults in both builds.
- Reset: assert reset_n low during ST_HI. State returns to IDLE, rsp_valid stays 0, and the next aligned load completes normally.
